// File: rtl/mag_search_sar.sv
// mag_search_sar: successive-approximation searcher for a magnitude comparator.
// It drives the comparator A input (probe_o) and reads back its less/greater/equal
// flags. From those it finds the value on the comparator B input, deciding one bit
// per clock from the MSB down. It stops early as soon as the comparator reports
// equality.
//
// Ports:
//   clk_i        system clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   start_i      request a search, accepted only when idle
//   cmp_less_i   comparator A_less_B  (probe < target)
//   cmp_great_i  comparator A_great_B (probe > target)
//   cmp_equal_i  comparator A_equal_B (probe == target)
//   probe_o      drives comparator A input
//   busy_o       high while probing or verifying
//   done_o       one-cycle completion pulse
//   result_o     discovered target value
//   found_o      result verified equal to target
//   err_o        illegal flag combination seen during last search
module mag_search_sar #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             cmp_less_i,
  input  logic             cmp_great_i,
  input  logic             cmp_equal_i,
  output logic [WIDTH-1:0] probe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             found_o,
  output logic             err_o
);

  localparam int unsigned     IdxW       = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxTop     = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ProbeFirst = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StProbe, StVerify, StDone} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] probe_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic             err_q;

  logic             flags_ok;
  logic [WIDTH-1:0] probe_step;

  // The comparator must assert exactly one flag. Anything else means the
  // comparator path is broken.
  always_comb begin
    flags_ok = ( cmp_less_i & ~cmp_great_i & ~cmp_equal_i) |
               (~cmp_less_i &  cmp_great_i & ~cmp_equal_i) |
               (~cmp_less_i & ~cmp_great_i &  cmp_equal_i);
  end

  // Decide the bit under test, then arm the next lower bit as a trial 1.
  always_comb begin
    probe_step = probe_q;
    if (cmp_great_i) begin
      probe_step[idx_q] = 1'b0;
    end
    if (idx_q != '0) begin
      probe_step[idx_q - IdxW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= IdxTop;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StProbe;
            probe_q <= ProbeFirst;
            idx_q   <= IdxTop;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StProbe: begin
          if (!flags_ok) begin
            result_q <= probe_q;
            found_q  <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (cmp_equal_i) begin
            result_q <= probe_q;
            found_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (idx_q == '0) begin
            probe_q <= probe_step;
            state_q <= StVerify;
          end else begin
            probe_q <= probe_step;
            idx_q   <= idx_q - IdxW'(1);
          end
        end
        StVerify: begin
          // found stays low only if the target moved mid-search.
          result_q <= probe_q;
          found_q  <= flags_ok & cmp_equal_i;
          err_q    <= ~flags_ok;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign probe_o  = probe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign found_o  = found_q;
  assign err_o    = err_q;

endmodule
